// File: rtl/pla_bist_vec_misr.sv
// BIST wrapper for one single-output PLA slice: a 25-bit LFSR drives the slice
// inputs, and the slice response is folded into a 16-bit MISR and a ones counter.
module pla_bist_vec_misr #(
  parameter int unsigned NUM_PATTERNS = 1024,
  parameter logic [24:0] LFSR_SEED    = 25'h0000001,
  parameter logic [15:0] MISR_SEED    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [24:0] x_out,
  input  logic        y_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic [15:0] ones_count,
  output logic [15:0] pattern_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [24:0] SEED_EFF = (LFSR_SEED == 25'h0000000) ? 25'h0000001 : LFSR_SEED;
  localparam logic [15:0] LAST_IDX = 16'(NUM_PATTERNS - 1);

  // Fibonacci LFSR, polynomial x^25 + x^22 + 1.
  function automatic logic [24:0] lfsr_step(input logic [24:0] s);
    return {s[23:0], s[24] ^ s[21]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic y);
    return {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3] ^ y};
  endfunction

  state_t      state_r, state_s;
  logic [24:0] lfsr_r, lfsr_s;
  logic [15:0] misr_r, misr_s;
  logic [15:0] ones_r, ones_s;
  logic [15:0] idx_r, idx_s;
  logic        busy_r, done_r;

  // Next-state and datapath update for the pattern/capture sequencer.
  always_comb begin
    state_s = state_r;
    lfsr_s  = lfsr_r;
    misr_s  = misr_r;
    ones_s  = ones_r;
    idx_s   = idx_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_RUN;
          lfsr_s  = SEED_EFF;
          misr_s  = MISR_SEED;
          ones_s  = 16'h0000;
          idx_s   = 16'h0000;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (abort) begin
          // Partial signature, count and index are kept for inspection.
          state_s = ST_IDLE;
          lfsr_s  = 25'h0000000;
        end else begin
          misr_s = misr_step(misr_r, y_in);
          ones_s = ones_r + {15'h0000, y_in};
          if (idx_r == LAST_IDX) begin
            state_s = ST_DONE;
            lfsr_s  = 25'h0000000;
          end else begin
            lfsr_s = lfsr_step(lfsr_r);
            idx_s  = idx_r + 16'h0001;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        lfsr_s  = 25'h0000000;
      end
    endcase
  end

  // State and datapath registers; status flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      lfsr_r  <= 25'h0000000;
      misr_r  <= 16'h0000;
      ones_r  <= 16'h0000;
      idx_r   <= 16'h0000;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      lfsr_r  <= lfsr_s;
      misr_r  <= misr_s;
      ones_r  <= ones_s;
      idx_r   <= idx_s;
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
    end
  end

  assign x_out       = lfsr_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign signature   = misr_r;
  assign ones_count  = ones_r;
  assign pattern_idx = idx_r;

endmodule
